demosaic_phase_ctrl: RTL

- Sequencer for the 5x5-window demosaic datapath. Tracks pixel column/row across a frame and decodes the Bayer site phase of each window centre.
- Phase selects which interpolation kernel (R@R, R@G-in-R-row, R@G-in-B-row, R@B, and the G/B equivalents) feeds the output mux. Also flags border pixels.
- Delays phase/position through a LAT-stage pipeline aligned with the registered kernel outputs, under valid/ready backpressure. Sits between the line-buffer window generator and the kernel output mux.

---
 rtl/demosaic_pkg.sv | 26 ++
 rtl/demosaic_tag_pipe.sv | 45 ++++
 rtl/demosaic_phase_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/demosaic_pkg.sv
// Shared encodings for the demosaic phase sequencer: Bayer site phases,
// sensor pattern codes and the controller FSM state values.
package demosaic_pkg;

    localparam logic [1:0] PH_R  = 2'b00;
    localparam logic [1:0] PH_GR = 2'b01;
    localparam logic [1:0] PH_GB = 2'b10;
    localparam logic [1:0] PH_B  = 2'b11;

    localparam logic [1:0] BAYER_RGGB = 2'b00;
    localparam logic [1:0] BAYER_GRBG = 2'b01;
    localparam logic [1:0] BAYER_GBRG = 2'b10;
    localparam logic [1:0] BAYER_BGGR = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FRAME = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Pattern codes are the phase of pixel (0,0), so XOR moves the site parity.
    function automatic logic [1:0] site_phase(input logic ybit, input logic xbit,
                                              input logic [1:0] pat);
        return {ybit, xbit} ^ pat;
    endfunction

endpackage

// File: rtl/demosaic_tag_pipe.sv
// LAT-deep stall-able sideband shift register; advances in lockstep with the
// kernel datapath registers so tags stay aligned with kernel outputs.
module demosaic_tag_pipe #(
    parameter int LAT = 2,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    input  logic         in_vld,
    input  logic [W-1:0] in_tag,
    output logic         out_vld,
    output logic [W-1:0] out_tag
);

    logic [LAT-1:0]        vld_pipe_q, vld_pipe_d;
    logic [LAT-1:0][W-1:0] tag_pipe_q, tag_pipe_d;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        tag_pipe_d = tag_pipe_q;
        if (adv) begin
            vld_pipe_d[0] = in_vld;
            tag_pipe_d[0] = in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
                tag_pipe_d[i] = tag_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    assign out_vld = vld_pipe_q[LAT-1];
    assign out_tag = tag_pipe_q[LAT-1];

endmodule

// File: rtl/demosaic_phase_ctrl.sv
// Demosaic window sequencer: tracks frame position, decodes Bayer site phase
// and border flags, and aligns them with the kernel pipeline under backpressure.
module demosaic_phase_ctrl
    import demosaic_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int LAT   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     cfg_bayer,
    input  logic           in_valid,
    input  logic           in_sof,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     phase,
    output logic           border,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           eol,
    output logic           eof,
    output logic           frame_done,
    output logic           err_sof,
    output logic           drop
);

    localparam logic [X_W-1:0] X_LAST  = X_W'(IMG_W - 1);
    localparam logic [X_W-1:0] X_BR_HI = X_W'(IMG_W - 3);
    localparam logic [X_W-1:0] X_BR_LO = X_W'(2);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [Y_W-1:0] Y_BR_HI = Y_W'(IMG_H - 3);
    localparam logic [Y_W-1:0] Y_BR_LO = Y_W'(2);
    localparam int TAG_W = 2 + 1 + X_W + Y_W + 2;

    state_t         state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [1:0]     pat_q, pat_d;
    logic           drop_q, drop_d, err_q, err_d, fdone_q, fdone_d;

    logic           stall, acc;
    logic           tag_vld, tag_eol, tag_eof, tag_border;
    logic [X_W-1:0] tag_x;
    logic [Y_W-1:0] tag_y;
    logic [1:0]     tag_pat, tag_phase;
    logic [TAG_W-1:0] pipe_out;

    assign stall    = out_valid && !out_ready;
    // Gated by rst_n so the port reads 0 while reset is held.
    assign in_ready = rst_n && !stall && (state_q != ST_DRAIN);
    assign acc      = in_valid && in_ready;

    always_comb begin
        tag_vld = 1'b0;
        tag_x   = x_q;
        tag_y   = y_q;
        tag_pat = pat_q;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pat_d   = pat_q;
        drop_d  = 1'b0;
        err_d   = 1'b0;
        fdone_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc && in_sof) begin
                    tag_vld = 1'b1;
                    tag_x   = '0;
                    tag_y   = '0;
                    tag_pat = cfg_bayer;
                end else if (acc) begin
                    drop_d = 1'b1;
                end
            end
            ST_FRAME: begin
                if (acc) begin
                    tag_vld = 1'b1;
                    if (in_sof) begin
                        err_d   = (x_q != '0) || (y_q != '0);
                        tag_x   = '0;
                        tag_y   = '0;
                        tag_pat = cfg_bayer;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready && eof) begin
                    fdone_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tag_eol    = (tag_x == X_LAST);
        tag_eof    = tag_eol && (tag_y == Y_LAST);
        tag_phase  = site_phase(tag_y[0], tag_x[0], tag_pat);
        tag_border = (tag_x < X_BR_LO) || (tag_x > X_BR_HI) ||
                     (tag_y < Y_BR_LO) || (tag_y > Y_BR_HI);

        // Counters hold the position the next accepted pixel will take.
        if (tag_vld) begin
            pat_d = tag_pat;
            if (tag_eof) begin
                x_d     = '0;
                y_d     = '0;
                state_d = ST_DRAIN;
            end else if (tag_eol) begin
                x_d     = '0;
                y_d     = tag_y + Y_W'(1);
                state_d = ST_FRAME;
            end else begin
                x_d     = tag_x + X_W'(1);
                y_d     = tag_y;
                state_d = ST_FRAME;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= BAYER_RGGB;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            fdone_q <= fdone_d;
        end
    end

    demosaic_tag_pipe #(.LAT(LAT), .W(TAG_W)) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (!stall),
        .in_vld (tag_vld),
        .in_tag ({tag_phase, tag_border, tag_x, tag_y, tag_eol, tag_eof}),
        .out_vld(out_valid),
        .out_tag(pipe_out)
    );

    assign {phase, border, x_pos, y_pos, eol, eof} = pipe_out;
    assign drop       = drop_q;
    assign err_sof    = err_q;
    assign frame_done = fdone_q;

endmodule
